// File: rtl/pheap_req_arb_pkg.sv
`timescale 1ns/1ps
// Shared types for the pipelined heap: opcodes, level status, key/value record
// and the request front-end's state and response types.
package pheap_req_arb_pkg;

  localparam int KEY_W = 8;
  localparam int VAL_W = 8;
  localparam int ID_W  = 4;

  typedef enum logic [1:0] {
    LEQ     = 2'd0,
    DEQ     = 2'd1,
    ENQ_DEQ = 2'd2
  } opcode_t;

  typedef enum logic [1:0] {
    WAIT       = 2'd0,
    DONE       = 2'd1,
    NEXT_LEVEL = 2'd2
  } done_t;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
  } kv_t;

  // An all-ones key sorts last, so it doubles as the "no entry" marker.
  localparam kv_t KV_EMPTY = '{key: '1, val: '0};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    EXEC  = 3'd2,
    RESP  = 3'd3,
    GAP   = 3'd4
  } arb_state_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    kv_t             kv;
    logic            err;
  } resp_t;

endpackage

// File: rtl/pheap_req_arb_rr_arbiter.sv
`timescale 1ns/1ps
// Combinational round-robin pick: first valid request at or after ptr,
// wrapping modulo NUM_REQ. The caller owns and updates the pointer.
module pheap_req_arb_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (enable && !any && valid[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/pheap_req_arb.sv
`timescale 1ns/1ps
// Request front-end for the pipelined heap: round-robin client arbitration,
// full/empty screening, level-1 start/done handshake and response return.
module pheap_req_arb
  import pheap_req_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ISSUE_GAP = 2,
  localparam int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  opcode_t [NUM_REQ-1:0] req_op,
  input  kv_t [NUM_REQ-1:0]     req_kv,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  resp_valid,
  output logic [IDX_W-1:0]      resp_id,
  output kv_t                   resp_kv,
  output logic                  resp_err,
  output logic                  heap_start,
  output opcode_t               heap_op,
  output kv_t                   heap_in,
  input  done_t                 heap_done,
  input  kv_t                   heap_out,
  input  logic                  heap_full,
  input  logic                  heap_empty,
  output logic                  busy
);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] grant_idx;
  logic [3:0]       gap_cnt;
  logic             grant_any, arb_en, reject, pass_thru;
  opcode_t          grant_op;
  kv_t              grant_kv;
  opcode_t          lat_op;
  kv_t              lat_kv;
  resp_t            lat_resp;
  logic             unused_id_hi;

  assign arb_en = (state == IDLE) && !rst;

  pheap_req_arb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .valid  (req_valid),
    .ptr    (ptr),
    .enable (arb_en),
    .grant  (req_ready),
    .idx    (grant_idx),
    .any    (grant_any)
  );

  assign grant_op  = req_op[grant_idx];
  assign grant_kv  = req_kv[grant_idx];
  assign reject    = (grant_op == LEQ && heap_full) || (grant_op == DEQ && heap_empty);
  assign pass_thru = (grant_op == ENQ_DEQ) && heap_empty;

  always_comb begin
    state_nxt  = state;
    heap_start = 1'b0;
    heap_op    = LEQ;
    heap_in    = KV_EMPTY;
    resp_valid = 1'b0;
    resp_id    = '0;
    resp_kv    = KV_EMPTY;
    resp_err   = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (grant_any) state_nxt = (reject || pass_thru) ? RESP : ISSUE;
      end
      ISSUE: begin
        heap_start = 1'b1;
        heap_op    = lat_op;
        heap_in    = lat_kv;
        state_nxt  = EXEC;
      end
      EXEC: begin
        heap_op = lat_op;
        heap_in = lat_kv;
        if (heap_done != WAIT) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_id    = lat_resp.id[IDX_W-1:0];
        resp_kv    = lat_resp.kv;
        resp_err   = lat_resp.err;
        state_nxt  = (ISSUE_GAP == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (gap_cnt <= 4'd1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers: state, arbitration pointer, drain-gap counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gap_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && grant_any)
        ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      if (state == RESP)
        gap_cnt <= 4'(ISSUE_GAP);
      else if (state == GAP)
        gap_cnt <= gap_cnt - 4'd1;
    end
  end

  // Request/response payload; outputs are gated by state so these need no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && grant_any) begin
      lat_op       <= grant_op;
      lat_kv       <= grant_kv;
      lat_resp.id  <= ID_W'(grant_idx);
      lat_resp.err <= reject;
      lat_resp.kv  <= reject ? KV_EMPTY : grant_kv;
    end else if (state == EXEC && heap_done != WAIT) begin
      // A plain enqueue has nothing to hand back.
      lat_resp.kv <= (lat_op == LEQ) ? KV_EMPTY : heap_out;
    end
  end

  assign unused_id_hi = ^lat_resp.id;

endmodule

// File: tb/tb_pheap_req_arb.sv
`timescale 1ns/1ps
// Directed bench for pheap_req_arb: a vector table of single requests plus
// hand-written round-robin and reset-during-EXEC sequences.
module tb_pheap_req_arb;
  import pheap_req_arb_pkg::*;

  localparam int NUM_REQ   = 4;
  localparam int ISSUE_GAP = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NUM_REQ-1:0]    req_valid = '0;
  opcode_t [NUM_REQ-1:0] req_op;
  kv_t [NUM_REQ-1:0]     req_kv;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  resp_valid;
  logic [1:0]            resp_id;
  kv_t                   resp_kv;
  logic                  resp_err;
  logic                  heap_start;
  opcode_t               heap_op;
  kv_t                   heap_in;
  done_t                 heap_done = WAIT;
  kv_t                   heap_out;
  logic                  heap_full = 1'b0;
  logic                  heap_empty = 1'b1;
  logic                  busy;

  logic       hold_wait = 1'b0;
  logic [7:0] top_key = 8'hFF;
  int         total = 0;
  int         bad = 0;

  pheap_req_arb #(.NUM_REQ(NUM_REQ), .ISSUE_GAP(ISSUE_GAP)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_kv     (req_kv),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_kv    (resp_kv),
    .resp_err   (resp_err),
    .heap_start (heap_start),
    .heap_op    (heap_op),
    .heap_in    (heap_in),
    .heap_done  (heap_done),
    .heap_out   (heap_out),
    .heap_full  (heap_full),
    .heap_empty (heap_empty),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Level-1 stand-in: finishes one cycle after start unless told to stall.
  assign heap_out = '{key: top_key, val: 8'h00};
  always @(posedge clk) heap_done <= (heap_start && !hold_wait) ? DONE : WAIT;

  typedef struct packed {
    logic [1:0] cl;
    opcode_t    op;
    logic [7:0] key;
    logic       full;
    logic       empty;
    logic [7:0] top;
    logic       exp_start;
    logic [3:0] exp_lat;
    logic       exp_err;
    logic [7:0] exp_key;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL wait_idle actual=busy required=idle");
    end
  endtask

  function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         resp_at, n, cyc;
    logic       start_seen;
    logic [1:0] r_id;
    kv_t        r_kv;
    logic       r_err;
    int         g_idx [5];
    int         g_cyc [5];

    vecs[0] = '{cl: 2'd0, op: LEQ,     key: 8'h10, full: 1'b0, empty: 1'b1, top: 8'hFF,
                exp_start: 1'b1, exp_lat: 4'd3, exp_err: 1'b0, exp_key: 8'hFF};
    vecs[1] = '{cl: 2'd2, op: DEQ,     key: 8'h00, full: 1'b0, empty: 1'b1, top: 8'hFF,
                exp_start: 1'b0, exp_lat: 4'd1, exp_err: 1'b1, exp_key: 8'hFF};
    vecs[2] = '{cl: 2'd1, op: LEQ,     key: 8'h22, full: 1'b1, empty: 1'b0, top: 8'h03,
                exp_start: 1'b0, exp_lat: 4'd1, exp_err: 1'b1, exp_key: 8'hFF};
    vecs[3] = '{cl: 2'd3, op: ENQ_DEQ, key: 8'h33, full: 1'b0, empty: 1'b1, top: 8'hFF,
                exp_start: 1'b0, exp_lat: 4'd1, exp_err: 1'b0, exp_key: 8'h33};
    vecs[4] = '{cl: 2'd0, op: ENQ_DEQ, key: 8'h33, full: 1'b0, empty: 1'b0, top: 8'h40,
                exp_start: 1'b1, exp_lat: 4'd3, exp_err: 1'b0, exp_key: 8'h40};
    vecs[5] = '{cl: 2'd1, op: DEQ,     key: 8'h00, full: 1'b0, empty: 1'b0, top: 8'h15,
                exp_start: 1'b1, exp_lat: 4'd3, exp_err: 1'b0, exp_key: 8'h15};
    vecs[6] = '{cl: 2'd2, op: ENQ_DEQ, key: 8'h33, full: 1'b1, empty: 1'b0, top: 8'h05,
                exp_start: 1'b1, exp_lat: 4'd3, exp_err: 1'b0, exp_key: 8'h05};
    vecs[7] = '{cl: 2'd3, op: DEQ,     key: 8'h00, full: 1'b1, empty: 1'b0, top: 8'h77,
                exp_start: 1'b1, exp_lat: 4'd3, exp_err: 1'b0, exp_key: 8'h77};

    for (int i = 0; i < NUM_REQ; i++) begin
      req_op[i] = LEQ;
      req_kv[i] = KV_EMPTY;
    end

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_start", 32'(heap_start), 32'd0);
    check("rst_heap_op", 32'(heap_op), 32'(LEQ));
    check("rst_heap_in", 32'(heap_in), 32'(KV_EMPTY));
    check("rst_resp", 32'({resp_valid, resp_err, resp_id}), 32'd0);
    check("rst_resp_kv", 32'(resp_kv), 32'(KV_EMPTY));

    // Single-request vector table.
    for (int v = 0; v < 8; v++) begin
      wait_idle();
      heap_full  = vecs[v].full;
      heap_empty = vecs[v].empty;
      top_key    = vecs[v].top;
      req_op[vecs[v].cl] = vecs[v].op;
      req_kv[vecs[v].cl] = '{key: vecs[v].key, val: 8'h5A};
      req_valid  = 4'b0001 << vecs[v].cl;
      #1 check($sformatf("v%0d_grant", v), 32'(req_ready), 32'(4'b0001 << vecs[v].cl));
      @(posedge clk);
      #1 req_valid = '0;
      start_seen = 1'b0;
      resp_at = -1;
      r_id = '0;
      r_kv = KV_EMPTY;
      r_err = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (heap_start) begin
          start_seen = 1'b1;
          check($sformatf("v%0d_heap_in", v), 32'(heap_in.key), 32'(vecs[v].key));
          check($sformatf("v%0d_heap_op", v), 32'(heap_op), 32'(vecs[v].op));
        end
        if (resp_valid && resp_at < 0) begin
          resp_at = k;
          r_id = resp_id;
          r_kv = resp_kv;
          r_err = resp_err;
        end
      end
      check($sformatf("v%0d_start", v), 32'(start_seen), 32'(vecs[v].exp_start));
      check($sformatf("v%0d_lat", v), 32'(resp_at), 32'(vecs[v].exp_lat));
      check($sformatf("v%0d_id", v), 32'(r_id), 32'(vecs[v].cl));
      check($sformatf("v%0d_err", v), 32'(r_err), 32'(vecs[v].exp_err));
      check($sformatf("v%0d_key", v), 32'(r_kv.key), 32'(vecs[v].exp_key));
    end

    // Round robin from pointer 0 with every client requesting.
    wait_idle();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    heap_full  = 1'b0;
    heap_empty = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_op[i] = LEQ;
      req_kv[i] = '{key: 8'(8'h60 + i), val: 8'h00};
    end
    req_valid = 4'b1111;
    n = 0;
    cyc = 0;
    while (n < 5 && cyc < 80) begin
      #1;
      if (|req_ready) begin
        check($sformatf("rr_onehot%0d", n), 32'($countones(req_ready)), 32'd1);
        g_idx[n] = onehot_idx(req_ready);
        g_cyc[n] = cyc;
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    req_valid = '0;
    check("rr_count", 32'(n), 32'd5);
    if (n == 5) begin
      for (int i = 0; i < 5; i++) begin
        check($sformatf("rr_order%0d", i), 32'(g_idx[i]), 32'(i % NUM_REQ));
        if (i > 0)
          check($sformatf("rr_space%0d", i), 32'(g_cyc[i] - g_cyc[i-1]), 32'(4 + ISSUE_GAP));
      end
    end

    // Reset while EXEC waits on the heap; the request is dropped silently.
    wait_idle();
    hold_wait = 1'b1;
    req_op[1] = LEQ;
    req_kv[1] = '{key: 8'h21, val: 8'h00};
    req_valid = 4'b0010;
    #1 check("exr_grant", 32'(req_ready), 32'b0010);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    check("exr_in_exec", 32'({busy, heap_start}), 32'b10);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    hold_wait = 1'b0;
    @(negedge clk);
    check("exr_busy", 32'(busy), 32'd0);
    check("exr_outs", 32'({heap_start, resp_valid, resp_err, resp_id, req_ready}), 32'd0);
    check("exr_heap_op", 32'(heap_op), 32'(LEQ));
    check("exr_heap_in", 32'(heap_in), 32'(KV_EMPTY));
    check("exr_resp_kv", 32'(resp_kv), 32'(KV_EMPTY));
    start_seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (resp_valid) start_seen = 1'b1;
    end
    check("exr_no_resp", 32'(start_seen), 32'd0);

    req_op[3] = LEQ;
    req_kv[3] = '{key: 8'h31, val: 8'h00};
    req_valid = 4'b1010;
    #1 check("exr_ptr0_grant", 32'(req_ready), 32'b0010);
    @(posedge clk);
    #1 req_valid = '0;
    resp_at = -1;
    r_id = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (resp_valid && resp_at < 0) begin
        resp_at = k;
        r_id = resp_id;
      end
    end
    check("exr_after_lat", 32'(resp_at), 32'd3);
    check("exr_after_id", 32'(r_id), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
